// File: rtl/rf_write_arbiter_pkg.sv
// Shared pipeline package: default widths for the register-file write path
// and the requester index encoding used by the write arbiter.
package rf_write_arbiter_pkg;

   localparam int unsigned RF_DATA_W = 32;
   localparam int unsigned RF_ADDR_W = 5;

   // Requester indices; also the encoding of the round-robin pointer.
   typedef enum logic {
      REQ_ALU = 1'b0,
      REQ_MEM = 1'b1
   } req_idx_e;

endpackage

// File: rtl/rf_write_arbiter_rr_arb2.sv
// Two-way round-robin grant logic (purely combinational).
// Ports:
//   req0_valid_i, req1_valid_i : requester pending flags
//   ptr_i                      : current round-robin pointer (favoured requester on contention)
//   gnt0_o, gnt1_o             : one-hot (or zero) grants
//   ptr_next_o                 : pointer value to load if a grant is taken
module rr_arb2
   import rf_write_arbiter_pkg::*;
(
   input  logic req0_valid_i,
   input  logic req1_valid_i,
   input  logic ptr_i,
   output logic gnt0_o,
   output logic gnt1_o,
   output logic ptr_next_o
);

   always_comb begin
      gnt0_o     = 1'b0;
      gnt1_o     = 1'b0;
      ptr_next_o = ptr_i;

      if (req0_valid_i && req1_valid_i) begin
         if (ptr_i == REQ_MEM) gnt1_o = 1'b1;
         else                  gnt0_o = 1'b1;
      end else if (req0_valid_i) begin
         gnt0_o = 1'b1;
      end else if (req1_valid_i) begin
         gnt1_o = 1'b1;
      end

      // After a grant the other requester is favoured next time.
      if (gnt0_o)      ptr_next_o = REQ_MEM;
      else if (gnt1_o) ptr_next_o = REQ_ALU;
   end

endmodule

// File: rtl/rf_write_arbiter.sv
// Register-file write arbiter: merges two write requesters onto a single
// register-file write port with round-robin fairness, and keeps a per-register
// busy scoreboard (set by issue-stage reservations, cleared on write-back).
// Ports:
//   clock, reset                  : clock, synchronous active-low reset
//   reqN_valid/addr/data          : requester N write request (valid/ready)
//   reqN_ready                    : combinational accept for requester N
//   rsv_valid, rsv_addr           : destination reservation from issue
//   wr_en, wr_addr, wr_data       : registered register-file write port
//   busy                          : scoreboard, one bit per register (bit 0 always 0)
module rf_write_arbiter
   import rf_write_arbiter_pkg::*;
#(
   parameter int unsigned DATA_W = RF_DATA_W,
   parameter int unsigned ADDR_W = RF_ADDR_W
) (
   input  logic                      clock,
   input  logic                      reset,
   input  logic                      req0_valid,
   input  logic [ADDR_W-1:0]         req0_addr,
   input  logic [DATA_W-1:0]         req0_data,
   output logic                      req0_ready,
   input  logic                      req1_valid,
   input  logic [ADDR_W-1:0]         req1_addr,
   input  logic [DATA_W-1:0]         req1_data,
   output logic                      req1_ready,
   input  logic                      rsv_valid,
   input  logic [ADDR_W-1:0]         rsv_addr,
   output logic                      wr_en,
   output logic [ADDR_W-1:0]         wr_addr,
   output logic [DATA_W-1:0]         wr_data,
   output logic [(1<<ADDR_W)-1:0]    busy
);

   localparam int unsigned NREG = 1 << ADDR_W;

   req_idx_e            ptr_q, ptr_d;
   logic                gnt0, gnt1, arb_ptr_next;
   logic                xfer;
   logic [ADDR_W-1:0]   sel_addr;
   logic [DATA_W-1:0]   sel_data;

   logic                wr_en_q;
   logic [ADDR_W-1:0]   wr_addr_q;
   logic [DATA_W-1:0]   wr_data_q;
   logic [NREG-1:0]     busy_q, busy_d;

   rr_arb2 u_arb (
      .req0_valid_i (req0_valid),
      .req1_valid_i (req1_valid),
      .ptr_i        (ptr_q),
      .gnt0_o       (gnt0),
      .gnt1_o       (gnt1),
      .ptr_next_o   (arb_ptr_next)
   );

   // No handshakes complete while reset is held.
   assign req0_ready = gnt0 & reset;
   assign req1_ready = gnt1 & reset;
   assign xfer       = req0_ready | req1_ready;

   assign sel_addr = req1_ready ? req1_addr : req0_addr;
   assign sel_data = req1_ready ? req1_data : req0_data;

   always_comb begin
      ptr_d = ptr_q;
      if (xfer) ptr_d = req_idx_e'(arb_ptr_next);
   end

   always_ff @(posedge clock) begin
      if (!reset) ptr_q <= REQ_ALU;
      else        ptr_q <= ptr_d;
   end

   // Writes to r0 complete the handshake but never reach the register file;
   // address/data are only loaded for real writes so they hold while wr_en is low.
   always_ff @(posedge clock) begin
      if (!reset) begin
         wr_en_q   <= 1'b0;
         wr_addr_q <= '0;
         wr_data_q <= '0;
      end else if (xfer && (sel_addr != '0)) begin
         wr_en_q   <= 1'b1;
         wr_addr_q <= sel_addr;
         wr_data_q <= sel_data;
      end else begin
         wr_en_q   <= 1'b0;
      end
   end

   // Clear applied before set so a same-edge reservation of the written
   // register wins (a newer producer is pending).
   always_comb begin
      busy_d = busy_q;
      if (wr_en_q) busy_d[wr_addr_q] = 1'b0;
      if (rsv_valid && (rsv_addr != '0)) busy_d[rsv_addr] = 1'b1;
      busy_d[0] = 1'b0;
   end

   always_ff @(posedge clock) begin
      if (!reset) busy_q <= '0;
      else        busy_q <= busy_d;
   end

   assign wr_en   = wr_en_q;
   assign wr_addr = wr_addr_q;
   assign wr_data = wr_data_q;
   assign busy    = busy_q;

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Self-checking bench for rf_write_arbiter: a reference model predicts the
// readies each cycle and pushes the expected write-port/scoreboard state into
// a queue, popped and compared after the following clock edge.
module tb_rf_write_arbiter;

   logic        clock = 1'b0;
   logic        reset;
   logic        req0_valid, req1_valid, rsv_valid;
   logic [4:0]  req0_addr, req1_addr, rsv_addr;
   logic [31:0] req0_data, req1_data;
   logic        req0_ready, req1_ready;
   logic        wr_en;
   logic [4:0]  wr_addr;
   logic [31:0] wr_data;
   logic [31:0] busy;

   always #5 clock = ~clock;

   rf_write_arbiter #(.DATA_W(32), .ADDR_W(5)) dut (
      .clock      (clock),
      .reset      (reset),
      .req0_valid (req0_valid),
      .req0_addr  (req0_addr),
      .req0_data  (req0_data),
      .req0_ready (req0_ready),
      .req1_valid (req1_valid),
      .req1_addr  (req1_addr),
      .req1_data  (req1_data),
      .req1_ready (req1_ready),
      .rsv_valid  (rsv_valid),
      .rsv_addr   (rsv_addr),
      .wr_en      (wr_en),
      .wr_addr    (wr_addr),
      .wr_data    (wr_data),
      .busy       (busy)
   );

   typedef struct {
      logic        en;
      logic [4:0]  addr;
      logic [31:0] data;
      logic [31:0] busy;
   } exp_t;

   exp_t        sb[$];
   int unsigned n_pass = 0;
   int unsigned n_total = 0;

   // model state
   logic        ptr_m = 1'b0;
   logic        wr_en_m = 1'b0;
   logic [4:0]  wr_addr_m = '0;
   logic [31:0] wr_data_m = '0;
   logic [31:0] busy_m = '0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_total++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
   endtask

   task automatic cyc(input logic rst_n,
                      input logic v0, input logic [4:0] a0, input logic [31:0] d0,
                      input logic v1, input logic [4:0] a1, input logic [31:0] d1,
                      input logic rv, input logic [4:0] ra,
                      output logic eg0, output logic eg1);
      exp_t e;
      @(negedge clock);
      reset = rst_n;
      req0_valid = v0; req0_addr = a0; req0_data = d0;
      req1_valid = v1; req1_addr = a1; req1_data = d1;
      rsv_valid = rv; rsv_addr = ra;
      #1;
      eg0 = 1'b0; eg1 = 1'b0;
      if (rst_n) begin
         if (v0 && v1) begin
            if (ptr_m) eg1 = 1'b1; else eg0 = 1'b1;
         end else if (v0) eg0 = 1'b1;
         else if (v1) eg1 = 1'b1;
      end
      chk("req0_ready", req0_ready, eg0);
      chk("req1_ready", req1_ready, eg1);

      e.en = 1'b0; e.addr = wr_addr_m; e.data = wr_data_m; e.busy = busy_m;
      if (!rst_n) begin
         e.addr = '0; e.data = '0; e.busy = '0;
      end else begin
         if (eg0 && a0 != 0) begin e.en = 1'b1; e.addr = a0; e.data = d0; end
         else if (eg1 && a1 != 0) begin e.en = 1'b1; e.addr = a1; e.data = d1; end
         if (wr_en_m) e.busy[wr_addr_m] = 1'b0;
         if (rv && ra != 0) e.busy[ra] = 1'b1;
      end
      if (!rst_n) ptr_m = 1'b0;
      else if (eg0) ptr_m = 1'b1;
      else if (eg1) ptr_m = 1'b0;
      sb.push_back(e);

      @(posedge clock);
      #1;
      if (sb.size() == 0) begin
         chk("scoreboard_empty", 1, 0);
      end else begin
         e = sb.pop_front();
         chk("wr_en", wr_en, e.en);
         chk("wr_addr", wr_addr, e.addr);
         chk("wr_data", wr_data, e.data);
         chk("busy", busy, e.busy);
         wr_en_m = e.en; wr_addr_m = e.addr; wr_data_m = e.data; busy_m = e.busy;
      end
   endtask

   task automatic idle(input logic rst_n);
      logic g0, g1;
      cyc(rst_n, 0, 0, 0, 0, 0, 0, 0, 0, g0, g1);
   endtask

   initial begin
      logic        g0, g1;
      logic        p0, p1;
      logic [4:0]  pa0, pa1;
      logic [31:0] pd0, pd1;

      reset = 1'b0;
      req0_valid = 0; req1_valid = 0; rsv_valid = 0;
      req0_addr = 0; req1_addr = 0; rsv_addr = 0;
      req0_data = 0; req1_data = 0;

      // reset: valid request and reservation must be ignored
      cyc(0, 1, 3, 32'h1111, 1, 4, 32'h2222, 1, 5, g0, g1);
      cyc(0, 0, 0, 0, 0, 0, 0, 1, 6, g0, g1);

      // single requester, same-cycle grant, one-cycle write latency
      cyc(1, 1, 3, 32'hDEADBEEF, 0, 0, 0, 0, 0, g0, g1);
      idle(1);

      // both valid straight after reset: 0,1,0,1
      idle(0);
      cyc(1, 1, 4, 32'h10, 1, 5, 32'h20, 0, 0, g0, g1);
      cyc(1, 1, 6, 32'h11, 1, 5, 32'h20, 0, 0, g0, g1);
      cyc(1, 1, 6, 32'h11, 1, 8, 32'h21, 0, 0, g0, g1);
      cyc(1, 1, 9, 32'h12, 1, 8, 32'h21, 0, 0, g0, g1);
      idle(1);

      // write to r0: handshake, no write, busy unchanged
      cyc(1, 0, 0, 0, 0, 0, 0, 1, 2, g0, g1);
      cyc(1, 0, 0, 0, 1, 0, 32'h55, 0, 0, g0, g1);
      idle(1);

      // reserve r7, write r7, busy clears after write-back edge
      cyc(1, 0, 0, 0, 0, 0, 0, 1, 7, g0, g1);
      idle(1);
      cyc(1, 1, 7, 32'hA7A7A7A7, 0, 0, 0, 0, 0, g0, g1);
      idle(1);
      idle(1);
      // re-reserve on the write-back edge keeps r7 busy
      cyc(1, 0, 0, 0, 0, 0, 0, 1, 7, g0, g1);
      cyc(1, 1, 7, 32'hB7B7B7B7, 0, 0, 0, 0, 0, g0, g1);
      cyc(1, 0, 0, 0, 0, 0, 0, 1, 7, g0, g1);
      idle(1);

      // acceptance followed by reset: write discarded, busy cleared
      cyc(1, 1, 2, 32'hCAFE0002, 0, 0, 0, 1, 9, g0, g1);
      cyc(0, 1, 3, 32'h3, 1, 4, 32'h4, 1, 10, g0, g1);
      cyc(1, 1, 3, 32'h3, 1, 4, 32'h4, 0, 0, g0, g1);
      cyc(1, 0, 3, 32'h3, 1, 4, 32'h4, 0, 0, g0, g1);

      // randomized traffic, requests held until accepted
      p0 = 0; p1 = 0; pa0 = 0; pa1 = 0; pd0 = 0; pd1 = 0;
      for (int i = 0; i < 60; i++) begin
         logic rst_n;
         if (!p0 && $urandom_range(0, 2) != 0) begin p0 = 1; pa0 = 5'($urandom); pd0 = $urandom; end
         if (!p1 && $urandom_range(0, 2) != 0) begin p1 = 1; pa1 = 5'($urandom); pd1 = $urandom; end
         rst_n = ($urandom_range(0, 24) != 0);
         cyc(rst_n, p0, pa0, pd0, p1, pa1, pd1, 1'($urandom), 5'($urandom), g0, g1);
         if (g0) p0 = 0;
         if (g1) p1 = 0;
      end
      idle(1);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/rf_write_arbiter.md
RF_WRITE_ARBITER -- requirements
Module: rf_write_arbiter

Interface
REQ-001 The block SHALL have parameter DATA_W, default 32, meaning write-data width.
REQ-002 The block SHALL have parameter ADDR_W, default 5, meaning register address width (2**ADDR_W registers).
REQ-003 The block SHALL have port clock, input, 1, the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port reset, input, 1, a synchronous, active-low reset.
REQ-005 The block SHALL have ports req0_valid, input, 1 and req1_valid, input, 1, meaning each requester has a write pending.
REQ-006 The block SHALL have ports req0_addr, input, ADDR_W and req1_addr, input, ADDR_W, meaning each requester's destination register.
REQ-007 The block SHALL have ports req0_data, input, DATA_W and req1_data, input, DATA_W, meaning each requester's write data.
REQ-008 The block SHALL have ports req0_ready, output, 1 and req1_ready, output, 1, meaning the requester's write is accepted this cycle.
REQ-009 The block SHALL have ports rsv_valid, input, 1 and rsv_addr, input, ADDR_W, meaning the issue stage reserves rsv_addr as a pending destination.
REQ-010 The block SHALL have ports wr_en, output, 1; wr_addr, output, ADDR_W; wr_data, output, DATA_W, which drive the register-file write port.
REQ-011 The block SHALL have port busy, output, 2**ADDR_W, meaning a scoreboard bit per register; bit set = write pending.

Function
REQ-012 Handshake SHALL be valid/ready: transfer occurs when reqN_valid and reqN_ready are both high; the requester holds valid, addr and data stable until transfer.
REQ-013 reqN_ready SHALL be combinational and at most one ready SHALL be high per cycle.
REQ-014 With one valid requester, that requester SHALL be granted in the same cycle.
REQ-015 With both valid, grant SHALL go to the requester indicated by a 1-bit round-robin pointer; after each transfer the pointer SHALL point to the non-granted requester.
REQ-016 The pointer SHALL NOT change in cycles with no transfer.
REQ-017 An accepted write SHALL appear on wr_en/wr_addr/wr_data exactly one cycle after acceptance (registered outputs); wr_en SHALL be low otherwise.
REQ-018 Accepted writes to address 0 SHALL complete the handshake, but wr_en SHALL stay low (register 0 never written).
REQ-019 wr_addr and wr_data SHALL hold their last values while wr_en is low.
REQ-020 Sustained throughput SHALL be one write per cycle; back-to-back grants are allowed.
REQ-021 A rising edge with rsv_valid high and rsv_addr nonzero SHALL set busy[rsv_addr].
REQ-022 A rising edge with wr_en high SHALL clear busy[wr_addr], so that busy reads low from the cycle in which the register file holds the new value.
REQ-023 If the reserve and the clear target the same register on the same edge, the set SHALL win (a newer producer is pending).
REQ-024 busy[0] SHALL be constant 0.
REQ-025 Reserving an already-busy register SHALL leave it busy with no error; clearing a non-busy register SHALL have no effect.

Reset
REQ-026 While reset is low at a rising edge, the block SHALL set wr_en=0, wr_addr=0, wr_data=0, busy=0 and the pointer to requester 0.
REQ-027 While reset is low, req0_ready and req1_ready SHALL be forced to 0.
REQ-028 A write accepted on the cycle before reset is asserted SHALL be discarded (wr_en low after the reset edge).
REQ-029 Reserves presented during reset SHALL be ignored.
REQ-030 The first cycle after reset deasserts SHALL operate normally.

Structure
REQ-031 DATA_W/ADDR_W defaults and the requester-index constants (REQ_ALU=0, REQ_MEM=1) SHALL reside in the shared pipeline package.
REQ-032 The round-robin grant logic SHALL be a sub-module named rr_arb2 (inputs: two valids and the pointer; outputs: two grants and the next pointer).
REQ-033 The write register and the scoreboard SHALL stay in the top module.

Verification
REQ-034 The bench SHALL cover: req0 only, addr=3, data=0xDEADBEEF -> req0_ready same cycle; next cycle wr_en=1, wr_addr=3, wr_data=0xDEADBEEF.
REQ-035 The bench SHALL cover: both requesters valid for 4 cycles straight after reset -> grant order 0,1,0,1 and four consecutive wr_en cycles.
REQ-036 The bench SHALL cover: req1 write to addr=0 -> req1_ready=1; wr_en stays 0; busy unchanged.
REQ-037 The bench SHALL cover: reserve r7, then write r7 -> busy[7]=1 until the edge that follows wr_en=1 for r7, then 0; a reserve of r7 on that same edge -> busy[7] stays 1.
REQ-038 The bench SHALL cover: reset driven low the cycle after an acceptance -> wr_en=0, busy=0, both readies 0; after release, both requesters valid -> req0 granted first.
